// File: rtl/fa_serial_nbit.sv
// fa_serial_nbit -- bit-serial adder. Adds two WIDTH-bit operands one bit
// per clock, LSB first, through a single full-adder cell.
//
// Optional feature macro: FA_SERIAL_SUB_EN
//   When defined, adds input 'sub'. With sub=1 the block captures ~b and
//   forces the carry-in to 1 (cin ignored), producing a - b mod 2^WIDTH with
//   cout=1 meaning "no borrow". With sub=0 it behaves as a plain adder.
//
// Parameters
//   WIDTH  operand width in bits (2..64)
//
// Ports
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   start  begin an addition (sampled only in IDLE)
//   sub    subtract select (FA_SERIAL_SUB_EN builds only)
//   a, b   operands
//   cin    carry-in
//   busy   high while in RUN or DONE
//   done   one-cycle completion pulse
//   sum    registered result, updated only on entry to DONE
//   cout   registered carry-out, updated only on entry to DONE
//
// Timing: start sampled at edge k -> WIDTH bit-edges (k+1..k+WIDTH) ->
// result copied at edge k+WIDTH+1 -> done high until edge k+WIDTH+2.

module fa_serial_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef FA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Values loaded into the shift/carry registers when start is accepted.
  logic [WIDTH-1:0] b_load;
  logic             c_load;

`ifdef FA_SERIAL_SUB_EN
  always_comb begin
    b_load = b;
    c_load = cin;
    if (sub) begin
      b_load = ~b;
      c_load = 1'b1;
    end
  end
`else
  always_comb begin
    b_load = b;
    c_load = cin;
  end
`endif

  // Full-adder cell from two 2-to-4 one-hot decoders.
  // Stage 1 decodes {a,b}: codes 01/10 give the half-sum, code 11 the
  // generate term. Stage 2 decodes {half-sum,carry} the same way; the final
  // carry is generate OR the stage-2 "both set" code.
  logic [3:0] dec_ab;
  logic [3:0] dec_pc;
  logic       half_s;
  logic       gen;
  logic       bit_s;
  logic       bit_c;

  always_comb begin
    dec_ab = 4'b0001 << {sh_a[0], sh_b[0]};
    half_s = dec_ab[1] | dec_ab[2];
    gen    = dec_ab[3];
    dec_pc = 4'b0001 << {half_s, carry};
    bit_s  = dec_pc[1] | dec_pc[2];
    bit_c  = gen | dec_pc[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      cnt   <= '0;
      carry <= 1'b0;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          // The counter stops at WIDTH; that extra RUN edge publishes the
          // result, which is what places done at edge k+WIDTH+1.
          if (cnt == LAST) begin
            sum   <= res;
            cout  <= carry;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            res   <= {bit_s, res[WIDTH-1:1]};
            carry <= bit_c;
            cnt   <= cnt + CW'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa_serial_nbit.sv
// Testbench for fa_serial_nbit: directed scenarios on an 8-bit instance plus
// randomized operands on WIDTH = 2, 8, 17 and 32 instances, each compared
// against arithmetic computed in the bench.

module tb_fa_serial_nbit;

  localparam int NW = 4;
  localparam int WS [NW] = '{2, 8, 17, 32};
`ifdef FA_SERIAL_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [NW-1:0] st;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        cin_in;
  logic        sub_in;

  logic [NW-1:0] bz;
  logic [NW-1:0] dn;
  logic [NW-1:0] co;
  logic [1:0]  s2;
  logic [7:0]  s8;
  logic [16:0] s17;
  logic [31:0] s32;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fa_serial_nbit #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[0]),
`ifdef FA_SERIAL_SUB_EN
    .sub(sub_in),
`endif
    .a(a_in[1:0]), .b(b_in[1:0]), .cin(cin_in),
    .busy(bz[0]), .done(dn[0]), .sum(s2), .cout(co[0]));

  fa_serial_nbit #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(st[1]),
`ifdef FA_SERIAL_SUB_EN
    .sub(sub_in),
`endif
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
    .busy(bz[1]), .done(dn[1]), .sum(s8), .cout(co[1]));

  fa_serial_nbit #(.WIDTH(17)) u17 (
    .clk(clk), .rst_n(rst_n), .start(st[2]),
`ifdef FA_SERIAL_SUB_EN
    .sub(sub_in),
`endif
    .a(a_in[16:0]), .b(b_in[16:0]), .cin(cin_in),
    .busy(bz[2]), .done(dn[2]), .sum(s17), .cout(co[2]));

  fa_serial_nbit #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(st[3]),
`ifdef FA_SERIAL_SUB_EN
    .sub(sub_in),
`endif
    .a(a_in[31:0]), .b(b_in[31:0]), .cin(cin_in),
    .busy(bz[3]), .done(dn[3]), .sum(s32), .cout(co[3]));

  function automatic logic [63:0] sum_of(input int i);
    case (i)
      0:       return {62'd0, s2};
      1:       return {56'd0, s8};
      2:       return {47'd0, s17};
      default: return {32'd0, s32};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete operation on instance i. Entered and left #1 after a
  // rising edge. The expected result is plain arithmetic on the operands.
  task automatic run_op(input int i, input logic [63:0] av, input logic [63:0] bv,
                        input logic ci, input logic sb, input string tag);
    int          w;
    int          n;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic [64:0] tot;
    logic [63:0] exp_s;
    logic        exp_c;
    w    = WS[i];
    mask = (64'd1 << w) - 64'd1;
    am   = av & mask;
    bm   = bv & mask;
    if (sb) begin
      exp_s = (am - bm) & mask;
      exp_c = (am >= bm);
    end else begin
      tot   = {1'b0, am} + {1'b0, bm} + {64'd0, ci};
      exp_s = tot[63:0] & mask;
      exp_c = tot[w];
    end
    a_in   = av;
    b_in   = bv;
    cin_in = ci;
    sub_in = sb;
    st[i]  = 1'b1;
    @(posedge clk);
    #1;
    st[i]  = 1'b0;
    // Scramble operands after capture; the running result must not care.
    a_in   = {$urandom, $urandom};
    b_in   = {$urandom, $urandom};
    cin_in = ~ci;
    sub_in = HAS_SUB ? ~sb : 1'b0;
    n = 0;
    do begin
      if (n == 0) chk({tag, " busy_after_start"}, {63'd0, bz[i]}, 64'd1);
      @(posedge clk);
      #1;
      n++;
    end while (!dn[i] && n < w + 10);
    chk({tag, " latency"}, 64'(n), 64'(w + 1));
    chk({tag, " done"}, {63'd0, dn[i]}, 64'd1);
    chk({tag, " sum"}, sum_of(i), exp_s);
    chk({tag, " cout"}, {63'd0, co[i]}, {63'd0, exp_c});
    @(posedge clk);
    #1;
    chk({tag, " done_one_cycle"}, {63'd0, dn[i]}, 64'd0);
    chk({tag, " idle_busy"}, {63'd0, bz[i]}, 64'd0);
  endtask

  initial begin
    int pulses;
    logic [63:0] seen;

    rst_n  = 1'b1;
    st     = '0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
    sub_in = 1'b0;

    // Reset is asynchronous: outputs must clear before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", {60'd0, bz}, 64'd0);
    chk("reset done", {60'd0, dn}, 64'd0);
    chk("reset sum8", sum_of(1), 64'd0);
    chk("reset cout", {60'd0, co}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic add and overflow.
    run_op(1, 64'h3C, 64'h15, 1'b0, 1'b0, "basic_add");
    run_op(1, 64'hFF, 64'h01, 1'b1, 1'b0, "overflow");

    // Result holds through IDLE with changing inputs and through the next RUN.
    a_in = 64'h77;
    b_in = 64'h11;
    repeat (5) @(posedge clk);
    #1;
    chk("hold_idle sum", sum_of(1), 64'h01);
    chk("hold_idle cout", {63'd0, co[1]}, 64'd1);
    st[1] = 1'b1;
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_run sum", sum_of(1), 64'h01);
    chk("hold_run cout", {63'd0, co[1]}, 64'd1);
    repeat (8) @(posedge clk);
    #1;
    chk("hold_run result", sum_of(1), 64'h88);

    // Start held high with new operands during RUN: ignored, one pulse only.
    a_in   = 64'h12;
    b_in   = 64'h34;
    cin_in = 1'b0;
    st[1]  = 1'b1;
    @(posedge clk);
    #1;
    a_in = 64'hFF;
    b_in = 64'hFF;
    cin_in = 1'b1;
    pulses = 0;
    seen   = '0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      #1;
      if (j == 9) st[1] = 1'b0;
      if (dn[1]) begin
        pulses++;
        seen = sum_of(1);
      end
    end
    chk("ignore_start pulses", 64'(pulses), 64'd1);
    chk("ignore_start sum", seen, 64'h46);
    chk("ignore_start idle", {63'd0, bz[1]}, 64'd0);

    // Reset in the middle of RUN (bit 4): immediate clear, no done pulse.
    a_in   = 64'hA5;
    b_in   = 64'h3C;
    cin_in = 1'b1;
    st[1]  = 1'b1;
    @(posedge clk);
    #1 st[1] = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset busy", {63'd0, bz[1]}, 64'd0);
    chk("midreset sum", sum_of(1), 64'd0);
    chk("midreset cout", {63'd0, co[1]}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk);
      #1;
      if (dn[1] || bz[1]) pulses++;
    end
    chk("midreset no_done", 64'(pulses), 64'd0);
    run_op(1, 64'h5A, 64'hA5, 1'b1, 1'b0, "after_reset");

`ifdef FA_SERIAL_SUB_EN
    run_op(1, 64'h10, 64'h20, 1'b1, 1'b1, "sub_borrow");
    run_op(1, 64'h20, 64'h10, 1'b0, 1'b1, "sub_noborrow");
    run_op(1, 64'h33, 64'h33, 1'b1, 1'b0, "sub_off_add");
`endif

    // Boundary operands on every width.
    for (int i = 0; i < NW; i++) begin
      run_op(i, '1, '1, 1'b1, 1'b0, "edge_all_ones");
      run_op(i, '0, '0, 1'b0, 1'b0, "edge_zero");
      run_op(i, '1, '0, 1'b1, 1'b0, "edge_carry_chain");
    end

    // Random regression on each width.
    for (int i = 0; i < NW; i++) begin
      for (int k = 0; k < 200; k++) begin
        run_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
               HAS_SUB ? 1'($urandom) : 1'b0, "random");
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        #0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
